// File: rtl/argmax_unit_if.sv
// Valid/ready stream carrying one signed class score per beat into the argmax stage.
interface argmax_unit_if #(
    parameter int SCORE_W = 16
);
    logic                      score_valid;
    logic signed [SCORE_W-1:0] score_data;
    logic                      score_last;
    logic                      score_ready;

    modport master (output score_valid, output score_data, output score_last, input score_ready);
    modport slave  (input score_valid, input score_data, input score_last, output score_ready);
endinterface

// File: rtl/argmax_unit.sv
// Final MNIST stage: tracks the running maximum of the class scores and reports the
// winning digit index, its score and a beat-count/score_last error with a sticky done.
module argmax_unit #(
    parameter int SCORE_W     = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    argmax_unit_if.slave       s_score,
    output logic               o_busy,
    output logic               o_done,
    output logic [IDX_W-1:0]   o_predicted_digit,
    output logic [SCORE_W-1:0] o_max_score,
    output logic               o_err
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                    r_state;
    logic [IDX_W-1:0]          r_count;
    logic signed [SCORE_W-1:0] r_run_max;
    logic [IDX_W-1:0]          r_run_idx;
    logic                      r_ready;
    logic                      r_busy;
    logic                      r_done;
    logic [IDX_W-1:0]          r_pred;
    logic [SCORE_W-1:0]        r_max_out;
    logic                      r_err;

    logic                      w_fire;
    logic                      w_take;
    logic                      w_at_last;
    logic                      w_final;
    logic                      w_err_beat;
    logic signed [SCORE_W-1:0] w_new_max;
    logic [IDX_W-1:0]          w_new_idx;

    // Beat 0 always loads; later beats must be strictly greater so ties keep the lower index.
    always_comb begin
        w_fire     = s_score.score_valid & r_ready & ~i_start;
        w_take     = (r_count == '0) || (s_score.score_data > r_run_max);
        w_at_last  = (r_count == LAST_IDX);
        w_final    = s_score.score_last | w_at_last;
        w_err_beat = s_score.score_last ^ w_at_last;
        w_new_max  = w_take ? s_score.score_data : r_run_max;
        w_new_idx  = w_take ? r_count : r_run_idx;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_run_max <= '0;
            r_run_idx <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pred    <= '0;
            r_max_out <= '0;
            r_err     <= 1'b0;
        end else if (i_start) begin
            // Start wins in every state: abort any partial vector and re-arm.
            r_state   <= S_COLLECT;
            r_count   <= '0;
            r_run_max <= '0;
            r_run_idx <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pred    <= '0;
            r_max_out <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_fire) begin
                        r_run_max <= w_new_max;
                        r_run_idx <= w_new_idx;
                        if (w_final) begin
                            r_state   <= S_DONE;
                            r_ready   <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_pred    <= w_new_idx;
                            r_max_out <= w_new_max;
                            r_err     <= w_err_beat;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_score.score_ready = r_ready;
    assign o_busy              = r_busy;
    assign o_done              = r_done;
    assign o_predicted_digit   = r_pred;
    assign o_max_score         = r_max_out;
    assign o_err               = r_err;
endmodule

// File: tb/tb_argmax_unit.sv
// Directed bench for argmax_unit: hand-computed vectors, immediate assertions, one summary line.
module tb_argmax_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  predicted_digit;
    logic [15:0] max_score;
    logic        err;
    int          checks;
    int          errors;

    logic signed [15:0] t2 [10];
    logic signed [15:0] t5 [5];

    argmax_unit_if #(.SCORE_W(16)) s_if ();

    argmax_unit #(.SCORE_W(16), .NUM_CLASSES(10), .IDX_W(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_start           (start),
        .s_score           (s_if.slave),
        .o_busy            (busy),
        .o_done            (done),
        .o_predicted_digit (predicted_digit),
        .o_max_score       (max_score),
        .o_err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [3:0] e_idx, input logic [15:0] e_max,
                                input logic e_err);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(s_if.score_ready), 32'd0);
        check({tag, "_digit"}, 32'(predicted_digit), 32'(e_idx));
        check({tag, "_max"}, 32'(max_score), 32'(e_max));
        check({tag, "_err"}, 32'(err), 32'(e_err));
    endtask

    // Start pulse for one cycle; optionally offers a beat on the same edge.
    task automatic pulse_start(input logic with_beat);
        @(negedge clk);
        start            = 1'b1;
        s_if.score_valid = with_beat;
        s_if.score_data  = 16'sd30000;
        s_if.score_last  = with_beat;
        @(negedge clk);
        start            = 1'b0;
        s_if.score_valid = 1'b0;
        s_if.score_last  = 1'b0;
    endtask

    task automatic send_beat(input logic signed [15:0] d, input logic l, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        s_if.score_valid = 1'b1;
        s_if.score_data  = d;
        s_if.score_last  = l;
        n = 0;
        while (!s_if.score_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("beat_ready_timeout", 32'(s_if.score_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_if.score_valid = 1'b0;
        s_if.score_last  = 1'b0;
    endtask

    task automatic send_t2(input logic random_gaps, input logic last_on_9);
        for (int i = 0; i < 10; i++)
            send_beat(t2[i], (i == 9) && last_on_9, random_gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(s_if.score_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_digit"}, 32'(predicted_digit), 32'd0);
        check({tag, "_max"}, 32'(max_score), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        t2 = '{-16'sd5, 16'sd3, 16'sd100, 16'sd7, -16'sd200, 16'sd0, 16'sd99, 16'sd100, 16'sd1, 16'sd2};
        t5 = '{16'sd1, 16'sd9, 16'sd4, 16'sd9, 16'sd2};
        rst_n            = 1'b0;
        start            = 1'b0;
        s_if.score_valid = 1'b0;
        s_if.score_data  = '0;
        s_if.score_last  = 1'b0;

        // T1: reset state, then idle after release ignores beats without start.
        #12;
        check_all_zero("t1_reset");
        @(negedge clk);
        rst_n = 1'b1;
        s_if.score_valid = 1'b1;
        s_if.score_data  = 16'sd50;
        repeat (3) @(negedge clk);
        s_if.score_valid = 1'b0;
        check_all_zero("t1_idle");

        // T2: tie at beats 2 and 7 keeps index 2; result sticky for 100+ cycles.
        pulse_start(1'b0);
        check("t2_busy_armed", 32'(busy), 32'd1);
        check("t2_ready_armed", 32'(s_if.score_ready), 32'd1);
        send_t2(1'b0, 1'b1);
        check_result("t2", 4'd2, 16'd100, 1'b0);
        repeat (110) @(negedge clk);
        check_result("t2_hold", 4'd2, 16'd100, 1'b0);

        // T1 from S_DONE: async reset clears outputs before any clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("t1_from_done");
        @(negedge clk);
        rst_n = 1'b1;

        // T3: all scores at the most negative value.
        pulse_start(1'b0);
        for (int i = 0; i < 10; i++) send_beat(-16'sd32768, i == 9, 0);
        check_result("t3", 4'd0, 16'h8000, 1'b0);

        // T4: random valid gaps, then beats offered in S_DONE are ignored.
        pulse_start(1'b0);
        send_t2(1'b1, 1'b1);
        check_result("t4", 4'd2, 16'd100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            s_if.score_valid = 1'b1;
            s_if.score_data  = 16'sd20000 + 16'(i);
            s_if.score_last  = 1'b1;
            check("t4_ready_in_done", 32'(s_if.score_ready), 32'd0);
            @(negedge clk);
        end
        s_if.score_valid = 1'b0;
        s_if.score_last  = 1'b0;
        check_result("t4_after_extra", 4'd2, 16'd100, 1'b0);

        // T5: early score_last flags err but still reports the partial result.
        pulse_start(1'b0);
        for (int i = 0; i < 5; i++) send_beat(t5[i], i == 4, 0);
        check_result("t5", 4'd1, 16'd9, 1'b1);

        // Missing score_last on beat 9 also flags err; start then clears everything.
        pulse_start(1'b0);
        send_t2(1'b0, 1'b0);
        check_result("nolast", 4'd2, 16'd100, 1'b1);
        pulse_start(1'b0);
        check("start_clr_done", 32'(done), 32'd0);
        check("start_clr_err", 32'(err), 32'd0);
        check("start_clr_digit", 32'(predicted_digit), 32'd0);
        check("start_clr_max", 32'(max_score), 32'd0);

        // T6: reset mid-collection after beat 4, then a clean run.
        for (int i = 0; i < 5; i++) send_beat(t2[i], 1'b0, 0);
        check("t6_busy_mid", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("t6_released");
        pulse_start(1'b0);
        send_t2(1'b0, 1'b1);
        check_result("t6", 4'd2, 16'd100, 1'b0);

        // T6b: restart mid-collection; the beat offered with start is dropped.
        pulse_start(1'b0);
        for (int i = 0; i < 5; i++) send_beat(t2[i], 1'b0, 0);
        pulse_start(1'b1);
        send_t2(1'b0, 1'b1);
        check_result("t6b", 4'd2, 16'd100, 1'b0);

        // Abort a partial vector holding a larger maximum; it must not leak.
        pulse_start(1'b0);
        for (int i = 0; i < 3; i++) send_beat(16'sd30000, 1'b0, 0);
        pulse_start(1'b0);
        send_t2(1'b0, 1'b1);
        check_result("abort_large", 4'd2, 16'd100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
